// File: rtl/imem_port_arbiter.sv
// Shares the instruction-memory dual-port RAM between the PC fetch path and the
// external controller: read-port arbitration, write pass-through, collision bypass.
module imem_port_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_flush,
    output logic                  fetch_gnt,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    output logic                  fetch_rvalid,

    input  logic                  ctl_rd_req,
    input  logic [ADDR_WIDTH-1:0] ctl_rd_addr,
    output logic                  ctl_rd_gnt,
    output logic [DATA_WIDTH-1:0] ctl_rd_data,
    output logic                  ctl_rd_valid,

    input  logic                  ctl_wr,
    input  logic [ADDR_WIDTH-1:0] ctl_waddr,
    input  logic [DATA_WIDTH-1:0] ctl_wr_data,

    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt;
    logic                  starve_hit;
    logic                  collide;
    logic                  ret_fetch;
    logic                  ret_ctl;
    logic                  byp;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [DATA_WIDTH-1:0] ret_data;
    logic [DATA_WIDTH-1:0] fetch_hold;
    logic [DATA_WIDTH-1:0] ctl_hold;

    // Fetch has priority until the controller has watched STARVE_LIMIT fetch grants go by.
    assign starve_hit = ctl_rd_req && (starve_cnt == STARVE_MAX);
    assign fetch_gnt  = !rst && fetch_req && !starve_hit;
    assign ctl_rd_gnt = !rst && ctl_rd_req && !fetch_gnt;
    assign mem_rd     = fetch_gnt || ctl_rd_gnt;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the output unassigned (latch).
        mem_rd_addr = '0;
        if (fetch_gnt) begin
            mem_rd_addr = fetch_addr;
        end else if (ctl_rd_gnt) begin
            mem_rd_addr = ctl_rd_addr;
        end
    end

    assign mem_wr      = ctl_wr;
    assign mem_wr_addr = ctl_waddr;
    assign mem_wr_data = ctl_wr_data;

    // The RAM returns the pre-write word on a same-address collision, so keep the new one.
    assign collide  = mem_rd && ctl_wr && (mem_rd_addr == ctl_waddr);
    assign ret_data = byp ? byp_data : mem_rd_data;

    assign fetch_rvalid = ret_fetch;
    assign ctl_rd_valid = ret_ctl;
    assign fetch_rdata  = ret_fetch ? ret_data : fetch_hold;
    assign ctl_rd_data  = ret_ctl ? ret_data : ctl_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            ret_fetch  <= 1'b0;
            ret_ctl    <= 1'b0;
            byp        <= 1'b0;
            byp_data   <= '0;
            fetch_hold <= '0;
            ctl_hold   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ret_fetch <= fetch_gnt && !fetch_flush;
            ret_ctl   <= ctl_rd_gnt;
            byp       <= collide;
            if (collide) begin
                byp_data <= ctl_wr_data;
            end
            if (ret_fetch) begin
                fetch_hold <= ret_data;
            end
            if (ret_ctl) begin
                ctl_hold <= ret_data;
            end
            if (ctl_rd_gnt || !ctl_rd_req) begin
                starve_cnt <= '0;
            end else if (fetch_gnt) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized scoreboard bench for imem_port_arbiter with a behavioural RAM and
// a word-level reference memory that predicts grants and returned data.
module tb_imem_port_arbiter;

    localparam int AW      = 11;
    localparam int DW      = 32;
    localparam int SL      = 4;
    localparam int N_WORDS = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_flush = 1'b0;
    logic          fetch_gnt;
    logic [DW-1:0] fetch_rdata;
    logic          fetch_rvalid;
    logic          ctl_rd_req = 1'b0;
    logic [AW-1:0] ctl_rd_addr = '0;
    logic          ctl_rd_gnt;
    logic [DW-1:0] ctl_rd_data;
    logic          ctl_rd_valid;
    logic          ctl_wr = 1'b0;
    logic [AW-1:0] ctl_waddr = '0;
    logic [DW-1:0] ctl_wr_data = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_wr;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;

    imem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_flush (fetch_flush),
        .fetch_gnt   (fetch_gnt),
        .fetch_rdata (fetch_rdata),
        .fetch_rvalid(fetch_rvalid),
        .ctl_rd_req  (ctl_rd_req),
        .ctl_rd_addr (ctl_rd_addr),
        .ctl_rd_gnt  (ctl_rd_gnt),
        .ctl_rd_data (ctl_rd_data),
        .ctl_rd_valid(ctl_rd_valid),
        .ctl_wr      (ctl_wr),
        .ctl_waddr   (ctl_waddr),
        .ctl_wr_data (ctl_wr_data),
        .mem_rd      (mem_rd),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr      (mem_wr),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with 1-cycle read latency; a same-cycle read sees the old word.
    logic [DW-1:0] ram [N_WORDS];
    always @(posedge clk) begin
        if (mem_wr) ram[mem_wr_addr] <= mem_wr_data;
        if (mem_rd) mem_rd_data <= ram[mem_rd_addr];
    end

    typedef struct {
        logic [DW-1:0] data;
        time           due;
    } exp_t;

    exp_t          fq[$];
    exp_t          cq[$];
    logic [DW-1:0] ref_mem [N_WORDS];
    int            fetch_run = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    logic          last_fg = 1'b0;
    logic          last_cg = 1'b0;
    logic          seen_cg = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(1) == 1) return AW'($urandom_range(15));
        return AW'($urandom_range(N_WORDS - 1));
    endfunction

    // One cycle: inputs already driven; predict grants and the word each read must return.
    task automatic step();
        logic          exp_f;
        logic          exp_c;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        @(negedge clk);
        exp_f = 1'b0;
        exp_c = 1'b0;
        if (!rst) begin
            exp_c = ctl_rd_req && (!fetch_req || fetch_run == SL);
            exp_f = fetch_req && !exp_c;
        end
        exp_a = exp_f ? fetch_addr : (exp_c ? ctl_rd_addr : '0);
        check("fetch_gnt", 32'(fetch_gnt), 32'(exp_f));
        check("ctl_rd_gnt", 32'(ctl_rd_gnt), 32'(exp_c));
        check("mem_rd", 32'(mem_rd), 32'(exp_f || exp_c));
        check("mem_rd_addr", 32'(mem_rd_addr), 32'(exp_a));
        check("mem_wr", 32'(mem_wr), 32'(ctl_wr));
        if (ctl_wr) begin
            check("mem_wr_addr", 32'(mem_wr_addr), 32'(ctl_waddr));
            check("mem_wr_data", mem_wr_data, ctl_wr_data);
        end
        if (exp_f || exp_c) begin
            exp_d = (ctl_wr && ctl_waddr == exp_a) ? ctl_wr_data : ref_mem[exp_a];
            if (exp_f && !fetch_flush) fq.push_back('{data: exp_d, due: $time + 10});
            if (exp_c) cq.push_back('{data: exp_d, due: $time + 10});
        end
        fetch_run = (!rst && ctl_rd_req && exp_f) ? fetch_run + 1 : 0;
        if (ctl_wr) ref_mem[ctl_waddr] = ctl_wr_data;
        last_fg = exp_f;
        last_cg = exp_c;
        seen_cg = ctl_rd_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_req   = 1'b0;
        fetch_flush = 1'b0;
        ctl_rd_req  = 1'b0;
        ctl_wr      = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ctl_wr      = 1'b1;
        ctl_waddr   = a;
        ctl_wr_data = d;
        step();
        ctl_wr      = 1'b0;
    endtask

    // Monitor: every return pulse is matched against the oldest prediction for that requester.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            check("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
            check("rst_ctl_rd_valid", 32'(ctl_rd_valid), 32'd0);
            check("rst_fetch_rdata", fetch_rdata, 32'd0);
            check("rst_ctl_rd_data", ctl_rd_data, 32'd0);
        end else begin
            if (fetch_rvalid) begin
                if (fq.size() == 0) begin
                    check("fetch_spurious_rvalid", 32'(fetch_rvalid), 32'd0);
                end else begin
                    e = fq.pop_front();
                    check("fetch_rvalid_time", 32'($time), 32'(e.due));
                    check("fetch_rdata", fetch_rdata, e.data);
                end
            end else if (fq.size() != 0 && fq[0].due <= $time) begin
                check("fetch_rvalid_missing", 32'(fetch_rvalid), 32'd1);
                void'(fq.pop_front());
            end
            if (ctl_rd_valid) begin
                if (cq.size() == 0) begin
                    check("ctl_spurious_valid", 32'(ctl_rd_valid), 32'd0);
                end else begin
                    e = cq.pop_front();
                    check("ctl_rd_valid_time", 32'($time), 32'(e.due));
                    check("ctl_rd_data", ctl_rd_data, e.data);
                end
            end else if (cq.size() != 0 && cq[0].due <= $time) begin
                check("ctl_rd_valid_missing", 32'(ctl_rd_valid), 32'd1);
                void'(cq.pop_front());
            end
        end
    end

    initial begin
        int ctl_cnt;
        int first_ctl;

        idle();
        repeat (3) step();
        rst = 1'b0;
        step();

        // Fill memory with addr ^ 0xA5A5A5A5, then alternate fetch-only / ctl-only reads.
        for (int a = 0; a < N_WORDS; a++) do_write(AW'(a), 32'(a) ^ 32'hA5A5_A5A5);
        for (int a = 0; a < N_WORDS; a++) begin
            if (a % 2 == 0) begin
                fetch_req  = 1'b1;
                fetch_addr = AW'(a);
            end else begin
                ctl_rd_req  = 1'b1;
                ctl_rd_addr = AW'(a);
            end
            step();
            idle();
        end
        step();

        // Single fetch.
        do_write(11'h010, 32'hDEAD_BEEF);
        fetch_req  = 1'b1;
        fetch_addr = 11'h010;
        step();
        idle();
        step();

        // Collision: read and write 0x055 together, then a later write must not leak in.
        do_write(11'h055, 32'h0);
        ctl_rd_req  = 1'b1;
        ctl_rd_addr = 11'h055;
        ctl_wr      = 1'b1;
        ctl_waddr   = 11'h055;
        ctl_wr_data = 32'h1234_5678;
        step();
        ctl_rd_req  = 1'b0;
        ctl_wr_data = 32'hCAFE_F00D;
        step();
        idle();
        step();

        // Flush: first grant discarded, second returns normally.
        fetch_req   = 1'b1;
        fetch_addr  = 11'h010;
        fetch_flush = 1'b1;
        step();
        fetch_flush = 1'b0;
        step();
        idle();
        fetch_flush = 1'b1;
        step();
        idle();
        step();

        // Starvation: both held high; controller must win exactly once in every five cycles.
        ctl_cnt   = 0;
        first_ctl = -1;
        fetch_req   = 1'b1;
        fetch_addr  = 11'h100;
        ctl_rd_req  = 1'b1;
        ctl_rd_addr = 11'h200;
        for (int i = 0; i < 20; i++) begin
            step();
            if (seen_cg) begin
                ctl_cnt++;
                if (first_ctl < 0) first_ctl = i;
                ctl_rd_addr = ctl_rd_addr + 11'd1;
            end else begin
                fetch_addr = fetch_addr + 11'd1;
            end
        end
        check("starve_first_ctl_cycle", 32'(first_ctl), 32'd4);
        check("starve_ctl_share", 32'(ctl_cnt), 32'd4);
        idle();
        step();

        // Reset with a fetch return in flight: the return is dropped.
        fetch_req  = 1'b1;
        fetch_addr = 11'h123;
        step();
        idle();
        rst = 1'b1;
        fq.delete();
        cq.delete();
        step();
        step();
        rst = 1'b0;
        step();
        step();

        // Randomized traffic with held requests, random writes and flushes.
        for (int i = 0; i < 3000; i++) begin
            if (!fetch_req && $urandom_range(2) != 0) begin
                fetch_req  = 1'b1;
                fetch_addr = rand_addr();
            end
            if (!ctl_rd_req && $urandom_range(2) != 0) begin
                ctl_rd_req  = 1'b1;
                ctl_rd_addr = rand_addr();
            end
            fetch_flush = ($urandom_range(4) == 0);
            ctl_wr      = ($urandom_range(1) == 1);
            ctl_waddr   = rand_addr();
            ctl_wr_data = $urandom;
            step();
            if (last_fg) fetch_req = 1'b0;
            if (last_cg) ctl_rd_req = 1'b0;
        end
        idle();
        repeat (4) step();

        check("fetch_queue_drained", 32'(fq.size()), 32'd0);
        check("ctl_queue_drained", 32'(cq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
